// File: rtl/uart_pkg.sv
// Shared types and helpers for the debug UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_BAUD       = 115_200;
  localparam int DEF_OVERSAMPLE = 16;

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    int den;
    int q;
    den = baud * os;
    q   = (clk_hz + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, restartable.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/debug_uart_rx.sv
// 8N1 receiver for the debugger command path: one byte buffer with sticky
// ready, framing-error and overrun flags, acknowledged by rdy_clr.
module debug_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  uart_rx_state_t state_q, state_d;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    dout_q, dout_d;
  logic          rdy_q, rdy_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          restart;
  logic          tick;

  assign rx_s = sync_q[1];

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    restart = 1'b0;
    // Clear first so a flag set later in this cycle takes priority.
    rdy_d   = rdy_q  & ~rdy_clr;
    ferr_d  = ferr_q & ~rdy_clr;
    ovr_d   = ovr_q  & ~rdy_clr;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tcnt_d  = '0;
          restart = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_q == HALF_LAST) begin
            tcnt_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            tcnt_d  = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            tcnt_d = '0;
            // Returning to IDLE at mid-stop leaves room for a back-to-back start bit.
            if (rx_s) begin
              dout_d  = shift_q;
              rdy_d   = 1'b1;
              if (rdy_q && !rdy_clr) ovr_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      tcnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout      = dout_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule
